preg_free_list_ctrl: RTL and testbench

- Physical-register free-list controller between the decode stage and rename.
- Decides rename readiness from the decoder's destination-register demand (rename_rd_request, 0..4), hands out up to 4 physical registers per cycle, and reclaims up to 4 per cycle from commit.
- Keeps a speculative head and a committed head so a pipeline flush restores the free list in one cycle.

---
 rtl/preg_free_list_ctrl_pkg.sv | 26 ++
 rtl/preg_free_list_ctrl_lane_prefix_count4.sv | 15 +
 rtl/preg_free_list_ctrl.sv | 118 +++++++++++
 tb/tb_preg_free_list_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preg_free_list_ctrl_pkg.sv
// Shared rename-stage types: register file sizing, preg index and decoded instruction bundle.
// Exports PREG_NUM, AREG_NUM, DEPTH, PREG_W, pointer widths, preg_idx_t, fl_ptr_t, decoded_instr_t.
package preg_free_list_ctrl_pkg;

    localparam int PREG_NUM = 64;
    localparam int AREG_NUM = 32;
    localparam int DEPTH    = PREG_NUM - AREG_NUM;
    localparam int PREG_W   = $clog2(PREG_NUM);
    localparam int AREG_W   = $clog2(AREG_NUM);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_idx_t;
    typedef logic [AREG_W-1:0] areg_idx_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;

    typedef struct packed {
        logic      valid;
        logic      rd_we;
        areg_idx_t rd;
        areg_idx_t rs1;
        areg_idx_t rs2;
        logic [31:0] imm;
    } decoded_instr_t;

endpackage

// File: rtl/preg_free_list_ctrl_lane_prefix_count4.sv
// Per-lane exclusive prefix count of a 4-lane valid vector, plus the total.
// Ports: valid[3:0] in; offset[k] = number of valid lanes below k; total = popcount.
module lane_prefix_count4 (
    input  logic            [3:0] valid,
    output logic [3:0][1:0]       offset,
    output logic            [2:0] total
);

    assign offset[0] = 2'd0;
    assign offset[1] = {1'b0, valid[0]};
    assign offset[2] = {1'b0, valid[0]} + {1'b0, valid[1]};
    assign offset[3] = offset[2] + {1'b0, valid[2]};
    assign total     = {1'b0, offset[3]} + {2'b0, valid[3]};

endmodule

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list: speculative/committed heads, 4-wide alloc and 4-wide reclaim.
// Ports: clk, rst, flush; alloc_req_num/fire/ready/preg; commit_rd_num; free_valid/preg; free_count; err_overflow.
module preg_free_list_ctrl
    import preg_free_list_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic            [2:0] alloc_req_num,
    input  logic                  alloc_fire,
    output logic                  alloc_ready,
    output preg_idx_t       [3:0] alloc_preg,
    input  logic            [2:0] commit_rd_num,
    input  logic            [3:0] free_valid,
    input  preg_idx_t       [3:0] free_preg,
    output logic      [PTR_W-1:0] free_count,
    output logic                  err_overflow
);

    fl_ptr_t   spec_head;
    fl_ptr_t   cmt_head;
    fl_ptr_t   tail;
    preg_idx_t list_q [DEPTH];

    fl_ptr_t req_ext;
    fl_ptr_t cmt_ext;
    fl_ptr_t room;
    fl_ptr_t tot_ext;
    fl_ptr_t n_kept;

    logic [3:0]      eff_valid;
    logic [3:0]      keep;
    logic [3:0][1:0] free_off;
    logic [2:0]      free_tot;
    logic            fire_ok;
    logic            fire_bad;
    logic            free_ovf;

    assign req_ext     = fl_ptr_t'(alloc_req_num);
    assign cmt_ext     = fl_ptr_t'(commit_rd_num);
    assign free_count  = tail - spec_head;
    assign alloc_ready = (free_count >= req_ext) && !flush;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            alloc_preg[k] = list_q[spec_head[IDX_W-1:0] + IDX_W'(k)];
        end
    end

    // Preg 0 is hardwired; a release of it is silently discarded.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            eff_valid[k] = free_valid[k] && (free_preg[k] != '0);
        end
    end

    lane_prefix_count4 u_free_pfx (
        .valid  (eff_valid),
        .offset (free_off),
        .total  (free_tot)
    );

    // Room is measured against the current speculative head; lanes past it are dropped.
    assign room     = fl_ptr_t'(DEPTH) - free_count;
    assign tot_ext  = fl_ptr_t'(free_tot);
    assign free_ovf = tot_ext > room;
    assign n_kept   = free_ovf ? room : tot_ext;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            keep[k] = eff_valid[k] && (fl_ptr_t'(free_off[k]) < room);
        end
    end

    // A fire during flush is discarded, not treated as a protocol error.
    assign fire_ok  = alloc_fire && alloc_ready;
    assign fire_bad = alloc_fire && !alloc_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_head    <= '0;
            cmt_head     <= '0;
            tail         <= fl_ptr_t'(DEPTH);
            err_overflow <= 1'b0;
        end else begin
            cmt_head <= cmt_head + cmt_ext;
            tail     <= tail + n_kept;
            if (flush) begin
                spec_head <= cmt_head + cmt_ext;
            end else if (fire_ok) begin
                spec_head <= spec_head + req_ext;
            end
            if (free_ovf || fire_bad) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                list_q[i] <= preg_idx_t'(AREG_NUM + i);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (keep[k]) begin
                    list_q[tail[IDX_W-1:0] + IDX_W'(free_off[k])] <= free_preg[k];
                end
            end
        end
    end

    a_commit_behind_spec: assert property (
        @(posedge clk) disable iff (rst)
        cmt_ext <= fl_ptr_t'(spec_head - cmt_head)
    );

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Randomized and directed bench for preg_free_list_ctrl against a queue-based free-list model.
// Ports of the DUT are all driven/observed here; one summary line closes the run.
module tb_preg_free_list_ctrl;
    import preg_free_list_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic           [2:0] alloc_req_num = '0;
    logic                 alloc_fire = 1'b0;
    logic                 alloc_ready;
    preg_idx_t      [3:0] alloc_preg;
    logic           [2:0] commit_rd_num = '0;
    logic           [3:0] free_valid = '0;
    preg_idx_t      [3:0] free_preg = '0;
    logic     [PTR_W-1:0] free_count;
    logic                 err_overflow;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Model: free_q holds every entry from the committed head onwards,
    // spec_off counts entries handed out but not yet committed.
    int free_q[$];
    int spec_off;
    bit m_err;

    preg_free_list_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_req_num (alloc_req_num),
        .alloc_fire    (alloc_fire),
        .alloc_ready   (alloc_ready),
        .alloc_preg    (alloc_preg),
        .commit_rd_num (commit_rd_num),
        .free_valid    (free_valid),
        .free_preg     (free_preg),
        .free_count    (free_count),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic int m_fc();
        return free_q.size() - spec_off;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q = {};
        for (int i = 0; i < DEPTH; i++) free_q.push_back(AREG_NUM + i);
        spec_off = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        int fc;
        int room;
        int pushed;
        int tmp;
        int adds[$];
        fc = m_fc();
        room = DEPTH - fc;
        pushed = 0;
        for (int k = 0; k < 4; k++) begin
            if (free_valid[k] && free_preg[k] != 0) begin
                if (pushed < room) begin
                    adds.push_back(int'(free_preg[k]));
                    pushed++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (alloc_fire && !flush) begin
            if (fc >= int'(alloc_req_num)) spec_off += int'(alloc_req_num);
            else m_err = 1'b1;
        end
        for (int i = 0; i < int'(commit_rd_num); i++) tmp = free_q.pop_front();
        spec_off -= int'(commit_rd_num);
        if (flush) spec_off = 0;
        foreach (adds[i]) free_q.push_back(adds[i]);
    endtask

    task automatic idle();
        flush = 1'b0;
        alloc_fire = 1'b0;
        alloc_req_num = '0;
        commit_rd_num = '0;
        free_valid = '0;
        free_preg = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        int fc;
        if (chk_on && !rst) begin
            fc = m_fc();
            chk("free_count", free_count, fc);
            chk("alloc_ready", alloc_ready, (fc >= int'(alloc_req_num)) && !flush);
            chk("err_overflow", err_overflow, m_err);
            for (int k = 0; k < 4; k++) begin
                if (k < fc) chk("alloc_preg", alloc_preg[k], free_q[spec_off + k]);
            end
        end
    end

    initial begin
        int fc;
        int lim;
        int nz;
        bit fl;

        // Reset state
        do_reset();
        chk_on = 1'b1;
        alloc_req_num = 3'd4;
        #2;
        chk("rst_ready", alloc_ready, 1);
        chk("rst_preg0", alloc_preg[0], 32);
        chk("rst_preg1", alloc_preg[1], 33);
        chk("rst_preg2", alloc_preg[2], 34);
        chk("rst_preg3", alloc_preg[3], 35);
        chk("rst_count", free_count, 32);
        chk("rst_err", err_overflow, 0);

        // Drain to empty
        alloc_req_num = 3'd4;
        alloc_fire = 1'b1;
        repeat (8) cyc();
        idle();
        #2;
        chk("empty_count", free_count, 0);
        alloc_req_num = 3'd1;
        #2;
        chk("empty_ready_req1", alloc_ready, 0);
        alloc_req_num = 3'd0;
        #2;
        chk("empty_ready_req0", alloc_ready, 1);
        alloc_req_num = 3'd1;
        alloc_fire = 1'b1;
        cyc();
        idle();
        #2;
        chk("bad_fire_err", err_overflow, 1);
        chk("bad_fire_count", free_count, 0);

        // Sparse free compaction from empty
        free_valid = 4'b1010;
        free_preg[1] = 6'd40;
        free_preg[3] = 6'd50;
        cyc();
        idle();
        #2;
        chk("sparse_count", free_count, 2);
        chk("sparse_preg0", alloc_preg[0], 40);
        chk("sparse_preg1", alloc_preg[1], 50);
        free_valid = 4'b0001;
        cyc();
        idle();
        #2;
        chk("zero_drop_count", free_count, 2);

        // Flush recovery
        do_reset();
        alloc_req_num = 3'd4;
        alloc_fire = 1'b1;
        cyc();
        alloc_req_num = 3'd3;
        commit_rd_num = 3'd2;
        cyc();
        idle();
        #2;
        chk("pre_flush_count", free_count, 25);
        flush = 1'b1;
        alloc_fire = 1'b1;
        alloc_req_num = 3'd4;
        #2;
        chk("flush_ready", alloc_ready, 0);
        cyc();
        idle();
        #2;
        chk("flush_count", free_count, 30);
        chk("flush_preg0", alloc_preg[0], 34);
        chk("flush_err", err_overflow, 0);

        // Wrap with simultaneous alloc/commit/free
        do_reset();
        alloc_req_num = 3'd2;
        alloc_fire = 1'b1;
        cyc();
        for (int j = 1; j < 20; j++) begin
            alloc_req_num = 3'd2;
            alloc_fire = 1'b1;
            commit_rd_num = 3'd2;
            free_valid = 4'b0011;
            free_preg[0] = PREG_W'(2 * j + 1);
            free_preg[1] = PREG_W'(2 * j + 2);
            cyc();
        end
        idle();
        #2;
        chk("wrap_count", free_count, 30);
        chk("wrap_preg0", alloc_preg[0], 11);
        chk("wrap_preg1", alloc_preg[1], 12);
        chk("wrap_err", err_overflow, 0);

        // Overflow and async reset
        do_reset();
        free_valid = 4'b0001;
        free_preg[0] = 6'd5;
        cyc();
        idle();
        #2;
        chk("ovf_err", err_overflow, 1);
        chk("ovf_count", free_count, 32);
        repeat (3) cyc();
        chk("ovf_sticky", err_overflow, 1);
        alloc_req_num = 3'd2;
        alloc_fire = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_count", free_count, 32);
        chk("arst_err", err_overflow, 0);
        chk("arst_preg0", alloc_preg[0], 32);
        cyc();
        idle();
        #1;
        rst = 1'b0;

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            fc = m_fc();
            fl = ($urandom_range(15) == 0);
            flush = fl;
            alloc_req_num = 3'($urandom_range(4));
            alloc_fire = !fl && (fc >= int'(alloc_req_num)) && ($urandom_range(3) != 0);
            commit_rd_num = 3'($urandom_range(spec_off < 4 ? spec_off : 4));
            lim = DEPTH - free_q.size();
            if (lim > 4) lim = 4;
            nz = 0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1) == 1) begin
                    free_valid[k] = 1'b1;
                    if (nz < lim && $urandom_range(7) != 0) begin
                        free_preg[k] = PREG_W'($urandom_range(PREG_NUM - 1, 1));
                        nz++;
                    end
                end
            end
            cyc();
        end
        idle();
        cyc();
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
